// File: rtl/caesar_sweep_core.sv
// Caesar-cipher sweep engine: auto/step advancing source symbol with a registered encrypt/decrypt result.
// Optional BCD outputs are enabled by defining CAESAR_BCD_OUT_EN.
module caesar_sweep_core #(
    parameter int ALPHA    = 26,
    parameter int W        = 5,
    parameter int TICK_DIV = 50000000
) (
    input  logic         CLOCK_50,
    input  logic         rst,
    input  logic         ENCRYPT,
    input  logic [W-1:0] key,
    input  logic         run,
    input  logic         step,
    output logic [W-1:0] src,
    output logic [W-1:0] dst,
    output logic [W-1:0] key_used,
    output logic         key_err,
    output logic         out_valid
`ifdef CAESAR_BCD_OUT_EN
    ,
    output logic [7:0]   src_bcd,
    output logic [7:0]   dst_bcd,
    output logic [7:0]   key_bcd
`endif
);

    localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [W:0]    ALPHA_X  = (W + 1)'(ALPHA);
    localparam logic [W-1:0]  SYM_LAST = W'(ALPHA - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          advance;
    logic          adv_d;
    logic          mode_q;
    logic [W:0]    sum;
    logic [W:0]    diff;

    // A step during RUN is ignored, so tick and step together still give a single advance.
    always_comb begin
        tick    = (state == RUN) && (cnt == CNT_LAST);
        advance = tick || ((state == PAUSE) && step);
        sum     = {1'b0, src} + {1'b0, key_used};
        diff    = {1'b0, src} + ALPHA_X - {1'b0, key_used};
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            src       <= '0;
            adv_d     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            adv_d     <= advance;
            out_valid <= adv_d;
            if (advance) begin
                src <= (src == SYM_LAST) ? '0 : src + W'(1);
            end
            if ((state != RUN) || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            case (state)
                IDLE:    state <= run ? RUN : PAUSE;
                RUN:     if (!run) state <= PAUSE;
                PAUSE:   if (run) state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

    // Key and mode are registered first, so a switch change reaches dst two edges later.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            key_used <= '0;
            key_err  <= 1'b0;
            mode_q   <= 1'b0;
            dst      <= '0;
        end else begin
            key_used <= ({1'b0, key} >= ALPHA_X) ? SYM_LAST : key;
            key_err  <= ({1'b0, key} >= ALPHA_X);
            mode_q   <= ENCRYPT;
            if (mode_q) begin
                dst <= (sum >= ALPHA_X) ? W'(sum - ALPHA_X) : W'(sum);
            end else begin
                dst <= (src >= key_used) ? (src - key_used) : W'(diff);
            end
        end
    end

`ifdef CAESAR_BCD_OUT_EN
    function automatic logic [7:0] to_bcd(input logic [W-1:0] v);
        logic [7:0] wide;
        wide = 8'(v);
        return ((wide / 8'd10) << 4) | (wide % 8'd10);
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            src_bcd <= 8'h00;
            dst_bcd <= 8'h00;
            key_bcd <= 8'h00;
        end else begin
            src_bcd <= to_bcd(src);
            dst_bcd <= to_bcd(dst);
            key_bcd <= to_bcd(key_used);
        end
    end
`endif

endmodule
